// File: rtl/seg_msg_buffer.sv
// Serially loaded segment-pattern buffer that replays its message over valid/ready.
// Build option: define SEG_MSG_LOOP_EN to repeat the message instead of stopping in DONE.
module seg_msg_buffer #(
  parameter int          DEPTH = 16,
  parameter logic [7:0]  BLANK = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ser_clk,
  input  logic                     ser_data,
  input  logic                     ser_latch,
  output logic [7:0]               out_pat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   msg_len,
  output logic                     overflow,
  output logic                     playing
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {LOAD, PLAY, DONE} state_t;

  state_t          state;
  logic [2:0]      clk_sync;
  logic [2:0]      latch_sync;
  logic [1:0]      data_sync;
  logic [6:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [7:0]      mem [DEPTH];

  logic            clk_pulse;
  logic            latch_pulse;
  logic            data_bit;
  logic            clr_load;
  logic [LW-1:0]   base_len;
  logic [LW-1:0]   len_after;
  logic [AW-1:0]   base_wptr;
  logic [2:0]      base_cnt;
  logic [7:0]      shift_next;
  logic            byte_done;
  logic            full;
  logic            wr_en;
  logic            start_play;
  logic            accept;
  logic            at_last;
  logic [AW-1:0]   rptr_inc;
  logic [AW-1:0]   rd_idx;
  logic [7:0]      rd_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= '0;
      latch_sync <= '0;
      data_sync  <= '0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ser_clk};
      latch_sync <= {latch_sync[1:0], ser_latch};
      data_sync  <= {data_sync[0], ser_data};
    end
  end

  assign clk_pulse   = clk_sync[1] & ~clk_sync[2];
  assign latch_pulse = latch_sync[1] & ~latch_sync[2];
  assign data_bit    = data_sync[1];

  // A ser_clk edge outside LOAD starts a fresh message before its bit is shifted in.
  always_comb begin
    clr_load   = clk_pulse && (state != LOAD);
    base_len   = clr_load ? '0 : msg_len;
    base_wptr  = clr_load ? '0 : wptr;
    base_cnt   = clr_load ? '0 : bit_cnt;
    shift_next = {shift_reg, data_bit};
    byte_done  = clk_pulse && (base_cnt == 3'd7);
    full       = (base_len == LW'(DEPTH));
    wr_en      = byte_done && !full;
    len_after  = base_len + LW'(wr_en);
    start_play = latch_pulse && (len_after != '0);
    accept     = (state == PLAY) && out_valid && out_ready;
    at_last    = ({1'b0, rptr} == (msg_len - LW'(1)));
    rptr_inc   = at_last ? '0 : rptr + AW'(1);
    rd_idx     = start_play ? '0 : rptr_inc;
    // Bypass so a byte completed in the same cycle as the latch is seen immediately.
    rd_byte    = (wr_en && (base_wptr == rd_idx)) ? shift_next : mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[base_wptr] <= shift_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      rptr      <= '0;
      wptr      <= '0;
      msg_len   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      overflow  <= 1'b0;
      out_pat   <= BLANK;
      out_valid <= 1'b0;
      playing   <= 1'b0;
    end else begin
      msg_len  <= len_after;
      wptr     <= base_wptr + AW'(wr_en);
      overflow <= (overflow && !clr_load) || (byte_done && full);
      bit_cnt  <= latch_pulse ? 3'd0 : base_cnt + 3'(clk_pulse);
      if (clk_pulse) shift_reg <= shift_next[6:0];

      if (start_play) begin
        state     <= PLAY;
        rptr      <= '0;
        out_pat   <= rd_byte;
        out_valid <= 1'b1;
        playing   <= 1'b1;
      end else if (clr_load) begin
        state     <= LOAD;
        out_pat   <= BLANK;
        out_valid <= 1'b0;
        playing   <= 1'b0;
      end else if (accept) begin
`ifdef SEG_MSG_LOOP_EN
        rptr    <= rptr_inc;
        out_pat <= rd_byte;
`else
        if (at_last) begin
          state     <= DONE;
          out_pat   <= BLANK;
          out_valid <= 1'b0;
          playing   <= 1'b0;
        end else begin
          rptr    <= rptr_inc;
          out_pat <= rd_byte;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg_msg_buffer.sv
// Directed bench for seg_msg_buffer: a queue-based message model checked every cycle,
// plus literal expectations at key points. Honors SEG_MSG_LOOP_EN like the design.
module tb_seg_msg_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_clk = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_latch = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_pat;
  logic       out_valid;
  logic [4:0] msg_len;
  logic       overflow;
  logic       playing;

  seg_msg_buffer #(.DEPTH(DEPTH), .BLANK(8'hFF)) dut (
    .clk(clk), .reset(reset), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_latch(ser_latch), .out_pat(out_pat), .out_valid(out_valid),
    .out_ready(out_ready), .msg_len(msg_len), .overflow(overflow), .playing(playing)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pins take effect two edges after being seen; message held as a queue.
  bit         hc[3], hl[3], hd[3];
  logic [7:0] msg[$];
  int         mode;           // 0 load, 1 play, 2 done
  int         idx;
  int         nbits;
  logic [7:0] acc;
  bit         m_ov;
  logic [7:0] e_pat = 8'hFF;
  bit         e_valid = 1'b0;

  always @(posedge clk) begin
    bit cp, lp, d, took;
    if (reset) begin
      msg.delete();
      mode = 0; idx = 0; nbits = 0; acc = 8'h00; m_ov = 1'b0;
      for (int i = 0; i < 3; i++) begin hc[i] = 0; hl[i] = 0; hd[i] = 0; end
    end else begin
      cp = hc[1] && !hc[2];
      lp = hl[1] && !hl[2];
      d  = hd[1];
      took = e_valid && out_ready;
      if (cp) begin
        if (mode != 0) begin
          msg.delete(); m_ov = 1'b0; nbits = 0; mode = 0;
        end
        acc = {acc[6:0], d};
        nbits++;
        if (nbits == 8) begin
          if (msg.size() < DEPTH) msg.push_back(acc);
          else m_ov = 1'b1;
          nbits = 0;
        end
      end
      if (lp) begin
        nbits = 0;
        if (msg.size() > 0) begin mode = 1; idx = 0; end
      end else if (mode == 1 && took) begin
        idx++;
        if (idx == msg.size()) begin
`ifdef SEG_MSG_LOOP_EN
          idx = 0;
`else
          mode = 2;
`endif
        end
      end
      hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = ser_clk;
      hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = ser_latch;
      hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = ser_data;
    end
    e_valid = (mode == 1);
    e_pat   = e_valid ? msg[idx] : 8'hFF;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_pat", out_pat, e_pat);
      cmp("m_valid", out_valid, e_valid);
      cmp("m_len", msg_len, msg.size());
      cmp("m_ovf", overflow, m_ov);
      cmp("m_playing", playing, e_valid);
    end
  end

  task automatic send_bit(input bit b, input bit with_latch);
    ser_data = b;
    repeat (4) @(negedge clk);
    ser_clk = 1'b1;
    if (with_latch) ser_latch = 1'b1;
    repeat (4) @(negedge clk);
    ser_clk = 1'b0;
    ser_latch = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic latch();
    ser_latch = 1'b1;
    repeat (4) @(negedge clk);
    ser_latch = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic step_ready(input bit r);
    out_ready = r;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    bit ready_pat[4];
    logic [7:0] a5;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (20) @(negedge clk);
    cmp("rst_pat", out_pat, 8'hFF);
    cmp("rst_valid", out_valid, 0);
    cmp("rst_len", msg_len, 0);
    cmp("rst_ovf", overflow, 0);

    // Two-byte message
    send_byte(8'h89);
    send_byte(8'h86);
    cmp("len2", msg_len, 2);
    latch();
    cmp("first_pat", out_pat, 8'h89);
    cmp("first_valid", out_valid, 1);
    step_ready(1'b1);
    cmp("second_pat", out_pat, 8'h86);
    step_ready(1'b1);
`ifdef SEG_MSG_LOOP_EN
    cmp("wrap_pat", out_pat, 8'h89);
    cmp("wrap_valid", out_valid, 1);
`else
    cmp("done_pat", out_pat, 8'hFF);
    cmp("done_valid", out_valid, 0);
`endif
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;

    // Stalls hold the byte
    latch();
    for (int i = 0; i < 16; i++) begin
      out_ready = ready_pat[i % 4];
      @(negedge clk);
    end
    out_ready = 1'b0;

    // Overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) send_byte(8'(i * 37 + 5));
    cmp("ovf_len", msg_len, 16);
    cmp("ovf_flag", overflow, 1);
    latch();
    cmp("ovf_first", out_pat, 8'h05);
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;

    // One byte plus a discarded partial
    send_byte(8'hC0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    cmp("c0_len", msg_len, 1);
    cmp("c0_ovf_cleared", overflow, 0);
    latch();
    cmp("c0_pat", out_pat, 8'hC0);
    step_ready(1'b1);
`ifdef SEG_MSG_LOOP_EN
    cmp("c0_again", out_pat, 8'hC0);
`else
    cmp("c0_done_pat", out_pat, 8'hFF);
    cmp("c0_done_play", playing, 0);
`endif

    // 8th bit arriving with the latch is included in playback
    a5 = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(a5[i], 1'b0);
    send_bit(a5[0], 1'b1);
    cmp("sim_len", msg_len, 1);
    cmp("sim_pat", out_pat, 8'hA5);
    cmp("sim_valid", out_valid, 1);

    // Reset during playback
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cmp("mid_rst_pat", out_pat, 8'hFF);
    cmp("mid_rst_valid", out_valid, 0);
    cmp("mid_rst_len", msg_len, 0);
    cmp("mid_rst_play", playing, 0);
    reset = 1'b0;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);

    // A ser_clk edge during PLAY returns to LOAD with an empty message
    send_byte(8'h3C);
    latch();
    cmp("reload_play", playing, 1);
    cmp("reload_pat", out_pat, 8'h3C);
    send_bit(1'b1, 1'b0);
    cmp("edge_play", playing, 0);
    cmp("edge_len", msg_len, 0);
    latch();
    cmp("empty_latch_play", playing, 0);
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
